// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch command arbiter.
// Holds the command, status and completion-error codes, the arbiter FSM
// state type, and small helpers for legality and the status each command
// should produce.
package stopwatch_pkg;

  // Command codes offered by the requesters.
  localparam logic [1:0] CmdNop   = 2'b00;
  localparam logic [1:0] CmdStart = 2'b01;
  localparam logic [1:0] CmdStop  = 2'b10;
  localparam logic [1:0] CmdReset = 2'b11;

  // Stopwatch state as reported on status.
  localparam logic [1:0] StatusIdle    = 2'b00;
  localparam logic [1:0] StatusRunning = 2'b01;
  localparam logic [1:0] StatusPaused  = 2'b10;

  // Completion codes reported with done.
  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  // Requester identifiers reported on done_id.
  localparam logic IdPanel = 1'b0;
  localparam logic IdHost  = 1'b1;

  typedef enum logic [1:0] {
    StArb,
    StIssue,
    StSettle,
    StResp
  } state_e;

  // Whether cmd may be executed with the stopwatch in the given state.
  // START from an undefined status (11) is treated as illegal.
  function automatic logic cmd_legal(logic [1:0] cmd, logic [1:0] status);
    case (cmd)
      CmdStart: return (status == StatusIdle) || (status == StatusPaused);
      CmdStop:  return status == StatusRunning;
      default:  return 1'b1;
    endcase
  endfunction

  // Status the stopwatch should settle to once cmd has taken effect.
  function automatic logic [1:0] expected_status(logic [1:0] cmd);
    case (cmd)
      CmdStart: return StatusRunning;
      CmdStop:  return StatusPaused;
      default:  return StatusIdle;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_cmd_arbiter_if.sv
// Bundle of the arbiter's handshake, status and command/response signals.
//   master : the requester/stopwatch side (drives offers and status)
//   slave  : the arbiter (drives ready, command pulses, done and busy)
// Signals:
//   pnl_valid/pnl_cmd/pnl_ready    panel requester handshake
//   host_valid/host_cmd/host_ready host requester handshake
//   status                         stopwatch state (00 idle, 01 running, 10 paused)
//   start/stop/reset               one-cycle command pulses to the stopwatch
//   done/done_id/done_err          one-cycle completion report
//   busy                           arbiter is not accepting new commands
interface stopwatch_cmd_arbiter_if;

  logic       pnl_valid;
  logic [1:0] pnl_cmd;
  logic       pnl_ready;
  logic       host_valid;
  logic [1:0] host_cmd;
  logic       host_ready;
  logic [1:0] status;
  logic       start;
  logic       stop;
  logic       reset;
  logic       done;
  logic       done_id;
  logic [1:0] done_err;
  logic       busy;

  modport master (
    output pnl_valid, pnl_cmd, host_valid, host_cmd, status,
    input  pnl_ready, host_ready, start, stop, reset, done, done_id, done_err, busy
  );

  modport slave (
    input  pnl_valid, pnl_cmd, host_valid, host_cmd, status,
    output pnl_ready, host_ready, start, stop, reset, done, done_id, done_err, busy
  );

endinterface

// File: rtl/sw_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   en        arbitration enabled; no grant is given while low
//   req[1:0]  requests (bit 0 panel, bit 1 host)
//   gnt[1:0]  combinational one-hot grant, only ever to a requesting input
// A grant here is a completed transfer (ready is the grant and it is only
// given to a valid requester), so the pointer moves on every grant.
module sw_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1: host was granted last. Resets to host so the panel wins the first tie.
  logic last_host_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_host_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_host_q <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_host_q <= gnt[1];
    end
  end

endmodule

// File: rtl/stopwatch_cmd_arbiter.sv
// Arbitrates stopwatch commands from a panel and a host requester.
// A granted command is checked against the current stopwatch status; legal
// START/STOP/RESET commands are issued as a one-cycle pulse and the arbiter
// then waits up to SETTLE_MAX cycles for status to reflect them. Every
// accepted command ends with a one-cycle done carrying requester id and
// result (ok, illegal, timeout).
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of stopwatch_cmd_arbiter_if (handshakes, status,
//        command pulses, done report, busy)
// Parameters:
//   SETTLE_MAX  cycles allowed for status to reflect an issued command
module stopwatch_cmd_arbiter
  import stopwatch_pkg::*;
#(
  parameter int unsigned SETTLE_MAX = 4
) (
  input logic                    clk,
  input logic                    rst,
  stopwatch_cmd_arbiter_if.slave bus
);

  localparam int unsigned CntW = (SETTLE_MAX < 1) ? 1 : $clog2(SETTLE_MAX + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      cmd_q;
  logic            id_q;
  logic            start_q;
  logic            stop_q;
  logic            reset_q;
  logic            done_q;
  logic            done_id_q;
  logic [1:0]      done_err_q;

  logic [1:0] gnt;
  logic       arb_en;
  logic       xfer;
  logic       sel_id;
  logic [1:0] sel_cmd;
  logic       sel_legal;

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign arb_en = (state_q == StArb) && !rst;

  sw_rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({bus.host_valid, bus.pnl_valid}),
    .gnt (gnt)
  );

  assign bus.pnl_ready  = gnt[0];
  assign bus.host_ready = gnt[1];

  assign xfer      = |gnt;
  assign sel_id    = gnt[1] ? IdHost : IdPanel;
  assign sel_cmd   = gnt[1] ? bus.host_cmd : bus.pnl_cmd;
  assign sel_legal = cmd_legal(sel_cmd, bus.status);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StArb;
      cnt_q      <= '0;
      cmd_q      <= CmdNop;
      id_q       <= IdPanel;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      reset_q    <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      done_err_q <= ErrOk;
    end else begin
      // Command pulses last exactly one cycle: the ISSUE cycle.
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;

      unique case (state_q)
        StArb: begin
          if (xfer) begin
            cmd_q <= sel_cmd;
            id_q  <= sel_id;
            if (sel_cmd == CmdNop || !sel_legal) begin
              // Nothing to issue: report straight away.
              state_q    <= StResp;
              done_q     <= 1'b1;
              done_id_q  <= sel_id;
              done_err_q <= (sel_cmd == CmdNop) ? ErrOk : ErrIllegal;
            end else begin
              state_q <= StIssue;
              start_q <= (sel_cmd == CmdStart);
              stop_q  <= (sel_cmd == CmdStop);
              reset_q <= (sel_cmd == CmdReset);
            end
          end
        end

        StIssue: begin
          state_q <= StSettle;
          cnt_q   <= CntW'(SETTLE_MAX);
        end

        StSettle: begin
          if (bus.status == expected_status(cmd_q)) begin
            state_q    <= StResp;
            done_q     <= 1'b1;
            done_id_q  <= id_q;
            done_err_q <= ErrOk;
          end else if (cnt_q <= CntW'(1)) begin
            // Last allowed cycle without a match; non-matching status
            // changes before this point are simply ignored.
            state_q    <= StResp;
            cnt_q      <= '0;
            done_q     <= 1'b1;
            done_id_q  <= id_q;
            done_err_q <= ErrTimeout;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StResp: begin
          state_q    <= StArb;
          done_q     <= 1'b0;
          done_id_q  <= 1'b0;
          done_err_q <= ErrOk;
        end

        default: state_q <= StArb;
      endcase
    end
  end

  assign bus.start    = start_q;
  assign bus.stop     = stop_q;
  assign bus.reset    = reset_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.done_err = done_err_q;
  assign bus.busy     = (state_q != StArb);

endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
// Directed bench for stopwatch_cmd_arbiter. The stimulus side pushes the
// expected pulse/done events (value and cycle) into a queue when a command
// transfers; an independent monitor pops and compares whenever the DUT
// shows a command pulse or done.
module tb_stopwatch_cmd_arbiter;
  import stopwatch_pkg::*;

  localparam int unsigned SettleMax = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stopwatch_cmd_arbiter_if sw_if ();

  stopwatch_cmd_arbiter #(
    .SETTLE_MAX (SettleMax)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  typedef struct {
    bit         is_done;  // 0: command pulse, 1: done report
    logic [2:0] val;      // pulse {reset,stop,start} or done {id,err}
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic push(input string name, input bit is_done, input logic [2:0] val,
                      input int at);
    exp_t e;
    e.name    = name;
    e.is_done = is_done;
    e.val     = val;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic score(input bit is_done, input logic [2:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_output: kind=%0d val=%0h at cycle %0d, nothing expected",
               is_done, val, cyc);
    end else begin
      e = sb.pop_front();
      cmp({e.name, "_kind"}, 32'(is_done), 32'(e.is_done));
      cmp({e.name, "_val"}, 32'(val), 32'(e.val));
      cmp({e.name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sw_if.start || sw_if.stop || sw_if.reset)
        score(1'b0, {sw_if.reset, sw_if.stop, sw_if.start});
      if (sw_if.done)
        score(1'b1, {sw_if.done_id, sw_if.done_err});
    end
  end

  task automatic offer(input bit host, input logic [1:0] cmd);
    if (host) begin
      sw_if.host_cmd   = cmd;
      sw_if.host_valid = 1'b1;
    end else begin
      sw_if.pnl_cmd   = cmd;
      sw_if.pnl_valid = 1'b1;
    end
  endtask

  task automatic withdraw(input bit host);
    if (host) sw_if.host_valid = 1'b0;
    else      sw_if.pnl_valid  = 1'b0;
  endtask

  // Waits (bounded) for the given requester to see ready; returns the
  // transfer cycle. Returns at the negedge of that cycle.
  task automatic wait_grant(input string name, input bit host, output int tcyc);
    bit got = 1'b0;
    tcyc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sw_if.pnl_ready && sw_if.host_ready)
        cmp({name, "_single_ready"}, 32'd2, 32'd1);
      if (host ? sw_if.host_ready : sw_if.pnl_ready) begin
        got  = 1'b1;
        tcyc = cyc;
      end else if (host ? sw_if.pnl_ready : sw_if.host_ready) begin
        cmp({name, "_wrong_grant"}, 32'(!host), 32'(host));
      end
    end
    cmp({name, "_grant"}, 32'(got), 32'd1);
  endtask

  // Waits (bounded) for the arbiter to go idle with all expectations met.
  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!sw_if.busy && sb.size() == 0) ok = 1'b1;
    end
    cmp({name, "_drain"}, 32'(ok), 32'd1);
  endtask

  // Both requesters offer NOP together; first_host says who must win.
  task automatic nop_tie(input string name, input bit first_host);
    int t;
    int t2;
    offer(1'b0, CmdNop);
    offer(1'b1, CmdNop);
    wait_grant({name, "_first"}, first_host, t);
    push({name, "_first_done"}, 1'b1, {first_host, ErrOk}, t + 1);
    @(posedge clk);
    #1 withdraw(first_host);
    wait_grant({name, "_second"}, !first_host, t2);
    cmp({name, "_second_xfer_cycle"}, t2, t + 2);
    push({name, "_second_done"}, 1'b1, {!first_host, ErrOk}, t2 + 1);
    @(posedge clk);
    #1 withdraw(!first_host);
    drain(name);
  endtask

  task automatic check_all_zero(input string name);
    cmp({name, "_pnl_ready"}, 32'(sw_if.pnl_ready), 32'd0);
    cmp({name, "_host_ready"}, 32'(sw_if.host_ready), 32'd0);
    cmp({name, "_pulses"}, 32'({sw_if.reset, sw_if.stop, sw_if.start}), 32'd0);
    cmp({name, "_done"}, 32'({sw_if.done, sw_if.done_id, sw_if.done_err}), 32'd0);
    cmp({name, "_busy"}, 32'(sw_if.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    rst              = 1'b1;
    sw_if.pnl_valid  = 1'b1;
    sw_if.pnl_cmd    = CmdStart;
    sw_if.host_valid = 1'b1;
    sw_if.host_cmd   = CmdReset;
    sw_if.status     = StatusIdle;

    // Reset state, with offers pending that must not be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1;
    sw_if.pnl_valid  = 1'b0;
    sw_if.host_valid = 1'b0;
    rst              = 1'b0;

    // Tie after reset: panel STOP then host RESET, status running.
    sw_if.status = StatusRunning;
    offer(1'b0, CmdStop);
    offer(1'b1, CmdReset);
    wait_grant("tieA_pnl", 1'b0, t);
    push("tieA_stop", 1'b0, 3'b010, t + 1);
    push("tieA_pnl_done", 1'b1, {IdPanel, ErrOk}, t + 3);
    @(posedge clk);
    #1 withdraw(1'b0);
    @(negedge clk);
    cmp("tieA_busy", 32'(sw_if.busy), 32'd1);
    cmp("tieA_host_ready_held_low", 32'(sw_if.host_ready), 32'd0);
    @(posedge clk);
    #1 sw_if.status = StatusPaused;
    wait_grant("tieA_host", 1'b1, t2);
    cmp("tieA_host_xfer_cycle", t2, t + 4);
    push("tieA_reset", 1'b0, 3'b100, t2 + 1);
    push("tieA_host_done", 1'b1, {IdHost, ErrOk}, t2 + 3);
    @(posedge clk);
    #1 withdraw(1'b1);
    @(posedge clk);
    #1 sw_if.status = StatusIdle;
    drain("tieA");

    // Last grant was host: panel wins the next tie.
    nop_tie("tieB", 1'b0);

    // Panel START from idle, status follows at N+2.
    sw_if.status = StatusIdle;
    offer(1'b0, CmdStart);
    wait_grant("start", 1'b0, t);
    push("start_pulse", 1'b0, 3'b001, t + 1);
    push("start_done", 1'b1, {IdPanel, ErrOk}, t + 3);
    @(posedge clk);
    #1 withdraw(1'b0);
    @(posedge clk);
    #1 sw_if.status = StatusRunning;
    drain("start");

    // Last grant was panel: host wins this tie.
    nop_tie("tieC", 1'b1);

    // Host STOP while idle is illegal.
    sw_if.status = StatusIdle;
    offer(1'b1, CmdStop);
    wait_grant("ill_stop", 1'b1, t);
    push("ill_stop_done", 1'b1, {IdHost, ErrIllegal}, t + 1);
    @(posedge clk);
    #1 withdraw(1'b1);
    drain("ill_stop");

    // Panel START while running is illegal.
    sw_if.status = StatusRunning;
    offer(1'b0, CmdStart);
    wait_grant("ill_start", 1'b0, t);
    push("ill_start_done", 1'b1, {IdPanel, ErrIllegal}, t + 1);
    @(posedge clk);
    #1 withdraw(1'b0);
    drain("ill_start");

    // Panel STOP never confirmed; a wrong status change is ignored -> timeout.
    sw_if.status = StatusRunning;
    offer(1'b0, CmdStop);
    wait_grant("tmo", 1'b0, t);
    push("tmo_stop", 1'b0, 3'b010, t + 1);
    push("tmo_done", 1'b1, {IdPanel, ErrTimeout}, t + 6);
    @(posedge clk);
    #1 withdraw(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 sw_if.status = StatusIdle;
    drain("tmo");

    // Reset during ISSUE: pulse cleared at once, no done afterwards.
    sw_if.status = StatusIdle;
    offer(1'b0, CmdStart);
    wait_grant("abort_issue", 1'b0, t);
    @(posedge clk);
    #1;
    rst = 1'b1;
    withdraw(1'b0);
    #1 check_all_zero("abort_issue");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 cmp("abort_issue_idle", 32'(sw_if.busy), 32'd0);
    // Pointer back to host by reset: panel wins even though it went last.
    nop_tie("tieD", 1'b0);

    // Reset during SETTLE after a host RESET pulse.
    sw_if.status = StatusRunning;
    offer(1'b1, CmdReset);
    wait_grant("abort_settle", 1'b1, t);
    push("abort_settle_reset", 1'b0, 3'b100, t + 1);
    @(posedge clk);
    #1 withdraw(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("abort_settle");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 cmp("abort_settle_idle", 32'(sw_if.busy), 32'd0);
    nop_tie("tieE", 1'b0);

    cmp("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
